// File: rtl/mux_4x1_rr_arbiter_pkg.sv
// Shared types and round-robin search helper for the 4:1 mux arbiter.
package mux_arb_pkg;
  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } rr_pick_t;

  // Walks the offsets backwards so the lowest offset from ptr wins last.
  function automatic rr_pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                       input logic [SEL_W-1:0]   ptr);
    rr_pick_t         p;
    logic [SEL_W-1:0] idx;
    p = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      idx = ptr + SEL_W'(i);
      if (req[idx]) begin
        p.found = 1'b1;
        p.idx   = idx;
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/mux_4x1_rr_arbiter_if.sv
// Requester/output bundle of the 4:1 round-robin mux arbiter.
interface mux_4x1_rr_arbiter_if #(parameter int DATA_W = 8);
  import mux_arb_pkg::*;
  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ-1:0][DATA_W-1:0] din;
  logic [NUM_REQ-1:0]             gnt;
  logic [SEL_W-1:0]               sel;
  logic                           valid_out;
  logic [DATA_W-1:0]              dout;

  modport master (output req, din, input gnt, sel, valid_out, dout);
  modport slave  (input req, din, output gnt, sel, valid_out, dout);
endinterface

// File: rtl/mux_4x1_rr_arbiter_bus.sv
// Combinational 4:1 data mux built as a tree of 2:1 stages (s0 then s1).
module mux_4x1_bus #(
  parameter int DATA_W = 8
) (
  input  logic [3:0][DATA_W-1:0] i_din,
  input  logic [1:0]             i_sel,
  output logic [DATA_W-1:0]      o_dout
);
  logic [DATA_W-1:0] w_lo, w_hi;

  assign w_lo   = i_sel[0] ? i_din[1] : i_din[0];
  assign w_hi   = i_sel[0] ? i_din[3] : i_din[2];
  assign o_dout = i_sel[1] ? w_hi : w_lo;
endmodule

// File: rtl/mux_4x1_rr_arbiter.sv
// Round-robin arbiter driving a shared 4:1 mux with a registered output.
// Optional grant timeout: define ARB_TIMEOUT_EN to force release after MAX_HOLD cycles.
module mux_4x1_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 16
) (
  input logic                  clk,
  input logic                  rst,
  mux_4x1_rr_arbiter_if.slave  bus
);
  if (MAX_HOLD < 2) begin : g_bad_hold
    $error("MAX_HOLD must be >= 2");
  end

  arb_state_t         r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [SEL_W-1:0]   r_sel;
  logic [SEL_W-1:0]   r_ptr;
  logic               r_valid;
  logic [DATA_W-1:0]  r_dout;

  rr_pick_t           w_pick;
  logic               w_own_req;
  logic               w_force;
  logic               w_keep;
  logic [DATA_W-1:0]  w_mux;

  assign w_pick    = rr_pick(bus.req, r_ptr);
  assign w_own_req = bus.req[r_sel];

`ifdef ARB_TIMEOUT_EN
  localparam int               HOLD_W   = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);
  logic [HOLD_W-1:0] r_hold_cnt;

  // Only yield on timeout when someone else is actually waiting.
  assign w_force = (r_state == ARB_BUSY) && (r_hold_cnt == HOLD_MAX) &&
                   (|(bus.req & ~r_gnt));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          r_hold_cnt <= '0;
    else if (r_state == ARB_IDLE)                     r_hold_cnt <= '0;
    else if (w_own_req && r_hold_cnt != HOLD_MAX)     r_hold_cnt <= r_hold_cnt + 1'b1;
  end
`else
  assign w_force = 1'b0;
`endif

  assign w_keep = (r_state == ARB_BUSY) && w_own_req && !w_force;

  mux_4x1_bus #(.DATA_W(DATA_W)) u_bus (
    .i_din  (bus.din),
    .i_sel  (r_sel),
    .o_dout (w_mux)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB_IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_valid <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_valid <= w_keep;
      r_dout  <= w_keep ? w_mux : '0;
      if (r_state == ARB_IDLE) begin
        if (w_pick.found) begin
          r_state <= ARB_BUSY;
          r_gnt   <= NUM_REQ'(1) << w_pick.idx;
          r_sel   <= w_pick.idx;
          r_ptr   <= w_pick.idx + 1'b1;
        end
      end else if (!w_keep) begin
        // Release always passes through IDLE, giving one dead cycle between owners.
        r_state <= ARB_IDLE;
        r_gnt   <= '0;
        r_sel   <= '0;
      end
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.sel       = r_sel;
  assign bus.valid_out = r_valid;
  assign bus.dout      = r_dout;
endmodule

// File: tb/tb_mux_4x1_rr_arbiter.sv
// Directed plus randomized checks of the round-robin mux arbiter against an owner/pointer model.
module tb_mux_4x1_rr_arbiter;
  localparam int DATA_W   = 8;
  localparam int MAX_HOLD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: owner index (-1 when idle), priority pointer, hold count.
  int              m_owner = -1;
  int              m_ptr   = 0;
  int              m_hold  = 0;
  logic            m_valid = 1'b0;
  logic [DATA_W-1:0] m_dout = '0;

  mux_4x1_rr_arbiter_if #(.DATA_W(DATA_W)) bus ();

  mux_4x1_rr_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [3:0] eg;
    logic [1:0] es;
    eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    es = (m_owner < 0) ? 2'd0 : 2'(m_owner);
    chk({tag, ".gnt"},   32'(bus.gnt),       32'(eg));
    chk({tag, ".sel"},   32'(bus.sel),       32'(es));
    chk({tag, ".valid"}, 32'(bus.valid_out), 32'(m_valid));
    chk({tag, ".dout"},  32'(bus.dout),      32'(m_dout));
    chk({tag, ".onehot"}, 32'($onehot0(bus.gnt)), 32'd1);
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_hold = 0; m_valid = 1'b0; m_dout = '0;
  endtask

  // Advance the model with the inputs present before the edge, then compare at negedge.
  task automatic tick(input string tag);
    logic [3:0]             r;
    logic [3:0][DATA_W-1:0] d;
    bit                     frc;
    bit                     nv;
    r   = bus.req;
    d   = bus.din;
    frc = 0;
`ifdef ARB_TIMEOUT_EN
    if (m_owner >= 0 && m_hold == MAX_HOLD-1 && (r & ~(4'b0001 << m_owner)) != 4'b0000) frc = 1;
`endif
    nv      = (m_owner >= 0) && r[m_owner] && !frc;
    m_valid = nv;
    m_dout  = nv ? d[m_owner] : '0;
    if (m_owner < 0) begin
      for (int off = 0; off < 4; off++)
        if (m_owner < 0 && r[(m_ptr + off) % 4]) begin
          m_owner = (m_ptr + off) % 4;
          m_ptr   = (m_owner + 1) % 4;
          m_hold  = 0;
        end
    end else if (!r[m_owner] || frc) begin
      m_owner = -1;
    end else if (m_hold < MAX_HOLD-1) begin
      m_hold++;
    end
    @(posedge clk);
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus.req = '0; bus.din = '0;
    model_reset();
    #1 check_model("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.req = '0;
    bus.din = '0;
    do_reset();

    // Single requester: grant after 1 edge, data after 2.
    bus.req = 4'b0100;
    bus.din[2] = 8'hA5;
    tick("t1a");
    chk("t1.gnt", 32'(bus.gnt), 32'h4);
    chk("t1.sel", 32'(bus.sel), 32'h2);
    tick("t1b");
    chk("t1.dout",  32'(bus.dout), 32'hA5);
    chk("t1.valid", 32'(bus.valid_out), 32'h1);
    bus.req = '0;
    tick("t1c"); tick("t1d");

    // All requesting, each owner holds 3 cycles: order 0,1,2,3,0.
    do_reset();
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick("t2g");
      chk("t2.order", 32'(bus.gnt), 32'(4'b0001 << (g % 4)));
      tick("t2h"); tick("t2h");
      bus.req[g % 4] = 1'b0;
      tick("t2r");
      chk("t2.gap", 32'(bus.gnt), 32'h0);
      bus.req = 4'b1111;
    end
    bus.req = '0;
    tick("t2z");

    // Pointer sits at 2 after granting 1; 1010 must go to 3 first.
    bus.req = 4'b0010; tick("t3a");
    bus.req = 4'b0000; tick("t3b");
    bus.req = 4'b1010; tick("t3c");
    chk("t3.first", 32'(bus.gnt), 32'h8);
    bus.req = 4'b0010; tick("t3d");
    tick("t3e");
    chk("t3.second", 32'(bus.gnt), 32'h2);
    bus.req = '0; tick("t3f"); tick("t3g");

    // Async reset while busy clears outputs with no clock edge.
    bus.req = 4'b0001; bus.din[0] = 8'h3C;
    tick("t4a"); tick("t4b");
    chk("t4.busy", 32'(bus.gnt), 32'h1);
    #2 rst = 1'b1;
    model_reset();
    #1 check_model("t4.async");
    @(negedge clk);
    rst = 1'b0;
    tick("t4c");
    chk("t4.regrant", 32'(bus.gnt), 32'h1);
    bus.req = '0; tick("t4d"); tick("t4e");

    // Owner 0 holds while 2 waits: timeout forces release only with the macro.
    bus.req = 4'b0001; tick("t5a");
    chk("t5.grant", 32'(bus.gnt), 32'h1);
    bus.req = 4'b0101;
    tick("t5b"); tick("t5c"); tick("t5d");
    chk("t5.hold", 32'(bus.gnt), 32'h1);
    tick("t5e");
`ifdef ARB_TIMEOUT_EN
    chk("t5.gap", 32'(bus.gnt), 32'h0);
    tick("t5f");
    chk("t5.next", 32'(bus.gnt), 32'h4);
`else
    chk("t5.keep", 32'(bus.gnt), 32'h1);
    tick("t5f");
    chk("t5.keep2", 32'(bus.gnt), 32'h1);
`endif
    bus.req = '0; tick("t5g"); tick("t5h");

    // Owner 1 drops as 3 rises: one idle cycle, then 3.
    bus.req = 4'b0010; tick("t6a"); tick("t6b");
    bus.req = 4'b1000; tick("t6c");
    chk("t6.gap",   32'(bus.gnt), 32'h0);
    chk("t6.valid", 32'(bus.valid_out), 32'h0);
    tick("t6d");
    chk("t6.next", 32'(bus.gnt), 32'h8);
    bus.req = '0; tick("t6e"); tick("t6f");

    // Random traffic: each req bit toggles with probability 1/4 per cycle.
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 3) == 0) bus.req[b] = ~bus.req[b];
      bus.din = $urandom();
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
